// File: rtl/hub75_pkg.sv
// Shared types, default geometry and helpers for the HUB75 row-control blocks.
// Used by the line transmitter, the BCM display timer and the row sequencer.
package hub75_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_BLANK,
        ST_LATCH
    } shift_state_t;

    localparam int hpixel_dflt        = 64;
    localparam int vpixel_dflt        = 64;
    localparam int bpp_dflt           = 8;
    localparam int segments_dflt      = 2;
    localparam int addr_width_dflt    = $clog2(hpixel_dflt * vpixel_dflt);
    localparam int pix_bit_width_dflt = $clog2(bpp_dflt);
    localparam int row_width_dflt     = $clog2(vpixel_dflt / segments_dflt);

    // Panel row driven by a frame-buffer address: segments share row lines,
    // so the line number folds onto the rows of one segment.
    function automatic int unsigned row_index(input int unsigned addr,
                                              input int unsigned hpixel,
                                              input int unsigned rows);
        return (addr / hpixel) % rows;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation on-time counter: load starts a slot of
// base_cycles_p << pix_bit cycles; blanking is high whenever no slot runs.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int bpp_p         = bpp_dflt,
    parameter int base_cycles_p = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [$clog2(bpp_p)-1:0] pix_bit,
    output logic                     running,
    output logic                     blanking
);

    localparam int cnt_width = $clog2((base_cycles_p << (bpp_p - 1)) + 1);
    localparam logic [cnt_width-1:0] base_count = cnt_width'(base_cycles_p);

    logic [cnt_width-1:0] count_reg;
    logic [cnt_width-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = base_count << pix_bit;
        end else if (count_reg != '0) begin
            count_next = count_reg - cnt_width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Both flags decode the same register, so OE and blanking flip together.
    assign running  = (count_reg != '0);
    assign blanking = (count_reg == '0);

endmodule

// File: rtl/hub75_line_tx.sv
// HUB75 line transmitter: fetches one row from the frame buffer, shifts one
// bit-plane out with a divided clock, latches it and times the OE slot.
module hub75_line_tx
    import hub75_pkg::*;
#(
    parameter int hpixel_p      = hpixel_dflt,
    parameter int vpixel_p      = vpixel_dflt,
    parameter int bpp_p         = bpp_dflt,
    parameter int segments_p    = segments_dflt,
    parameter int base_cycles_p = 16,
    localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
    localparam int pix_bit_width_p = $clog2(bpp_p),
    localparam int row_width_p     = $clog2(vpixel_p / segments_p)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    i_clk_div,
    input  logic                          i_tx_start,
    input  logic [addr_width_p-1:0]       i_init_addr,
    input  logic [pix_bit_width_p-1:0]    i_pix_bit,
    input  logic                          i_timer_en,
    output logic                          o_tx_ready,
    output logic                          o_blanking,
    output logic                          o_rd_en,
    output logic [addr_width_p-1:0]       o_rd_addr,
    input  logic [segments_p*3*bpp_p-1:0] i_rd_data,
    output logic                          o_hub_clk,
    output logic [segments_p*3-1:0]       o_hub_rgb,
    output logic                          o_hub_lat,
    output logic                          o_hub_oe_n,
    output logic [row_width_p-1:0]        o_hub_row
);

    localparam int rows_p  = vpixel_p / segments_p;
    localparam int pix_w   = $clog2(hpixel_p);
    localparam int chans_p = segments_p * 3;
    localparam logic [pix_w-1:0] last_pix     = pix_w'(hpixel_p - 1);
    localparam logic [pix_w-1:0] pre_last_pix = pix_w'(hpixel_p - 2);

    shift_state_t state_reg, state_next;

    logic [addr_width_p-1:0]    addr_reg;
    logic [addr_width_p-1:0]    rd_addr_reg;
    logic [pix_bit_width_p-1:0] pix_bit_reg;
    logic [3:0]                 div_reg;
    logic [3:0]                 phase_reg;
    logic [pix_w-1:0]           pix_cnt_reg;
    logic                       lead_reg;
    logic                       hub_clk_reg;
    logic                       rd_en_reg;
    logic                       rd_valid_reg;
    logic                       lat_cnt_reg;
    logic [chans_p-1:0]         rgb_reg;
    logic [chans_p-1:0]         buf_reg;
    logic [chans_p-1:0]         plane_bits;
    logic [row_width_p-1:0]     row_reg;

    logic phase_end;
    logic shift_done;
    logic timer_load;
    logic timer_running;
    logic timer_blanking;
    logic tx_ready;
    logic hub_lat;

    // Pick the selected bit-plane out of every channel of the read word.
    genvar gi;
    generate
        for (gi = 0; gi < chans_p; gi++) begin : g_plane
            logic [bpp_p-1:0] chan;
            assign chan           = i_rd_data[gi*bpp_p +: bpp_p];
            assign plane_bits[gi] = chan[pix_bit_reg];
        end
    endgenerate

    assign phase_end  = (phase_reg == div_reg);
    assign shift_done = (state_reg == ST_SHIFT) && !lead_reg && phase_end &&
                        hub_clk_reg && (pix_cnt_reg == last_pix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (i_tx_start)     state_next = ST_SHIFT;
            ST_SHIFT:      if (shift_done)     state_next = ST_WAIT_BLANK;
            ST_WAIT_BLANK: if (timer_blanking) state_next = ST_LATCH;
            ST_LATCH:      if (lat_cnt_reg)    state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = 1'b0;
        hub_lat    = 1'b0;
        timer_load = 1'b0;
        case (state_reg)
            ST_IDLE:  tx_ready = 1'b1;
            ST_LATCH: begin
                hub_lat    = 1'b1;
                timer_load = lat_cnt_reg;
            end
            default: ;
        endcase
    end

    // Datapath. A lead-in phase waits for pixel 0 to arrive with the shift
    // clock held low; afterwards each low phase prefetches the next pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg     <= '0;
            rd_addr_reg  <= '0;
            pix_bit_reg  <= '0;
            div_reg      <= '0;
            phase_reg    <= '0;
            pix_cnt_reg  <= '0;
            lead_reg     <= 1'b0;
            hub_clk_reg  <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            lat_cnt_reg  <= 1'b0;
            rgb_reg      <= '0;
            buf_reg      <= '0;
            row_reg      <= '0;
        end else begin
            rd_en_reg    <= 1'b0;
            rd_valid_reg <= rd_en_reg;
            if (rd_valid_reg) begin
                buf_reg <= plane_bits;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (i_tx_start) begin
                        addr_reg    <= i_init_addr;
                        pix_bit_reg <= i_pix_bit;
                        div_reg     <= i_clk_div;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= i_init_addr;
                        lead_reg    <= 1'b1;
                        phase_reg   <= '0;
                        pix_cnt_reg <= '0;
                        hub_clk_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (lead_reg) begin
                        if (rd_valid_reg) begin
                            rgb_reg     <= plane_bits;
                            lead_reg    <= 1'b0;
                            phase_reg   <= '0;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= rd_addr_reg + addr_width_p'(1);
                        end
                    end else if (!phase_end) begin
                        phase_reg <= phase_reg + 4'd1;
                    end else begin
                        phase_reg   <= '0;
                        hub_clk_reg <= ~hub_clk_reg;
                        // Falling edge: present the next pixel, which either
                        // arrives this cycle (div 0) or was buffered earlier.
                        if (hub_clk_reg && (pix_cnt_reg != last_pix)) begin
                            pix_cnt_reg <= pix_cnt_reg + pix_w'(1);
                            rgb_reg     <= rd_valid_reg ? plane_bits : buf_reg;
                            if (pix_cnt_reg < pre_last_pix) begin
                                rd_en_reg   <= 1'b1;
                                rd_addr_reg <= rd_addr_reg + addr_width_p'(1);
                            end
                        end
                    end
                end
                ST_WAIT_BLANK: begin
                    if (timer_blanking) begin
                        row_reg     <= row_width_p'(row_index(32'(addr_reg), hpixel_p, rows_p));
                        lat_cnt_reg <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    lat_cnt_reg <= ~lat_cnt_reg;
                end
                default: ;
            endcase
        end
    end

    hub75_bcm_timer #(
        .bpp_p         (bpp_p),
        .base_cycles_p (base_cycles_p)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .pix_bit  (pix_bit_reg),
        .running  (timer_running),
        .blanking (timer_blanking)
    );

    assign o_tx_ready = tx_ready;
    assign o_blanking = timer_blanking;
    assign o_rd_en    = rd_en_reg;
    assign o_rd_addr  = rd_addr_reg;
    assign o_hub_clk  = hub_clk_reg;
    assign o_hub_rgb  = rgb_reg;
    assign o_hub_lat  = hub_lat;
    assign o_hub_oe_n = ~(timer_running & i_timer_en);
    assign o_hub_row  = row_reg;

endmodule

// File: tb/tb_hub75_line_tx.sv
// Directed bench for hub75_line_tx: a synchronous frame-buffer model feeds the
// DUT while a negedge monitor collects shift/latch/display statistics per row.
module tb_hub75_line_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_clk_div;
    logic        i_tx_start;
    logic [11:0] i_init_addr;
    logic [2:0]  i_pix_bit;
    logic        i_timer_en;
    logic        o_tx_ready;
    logic        o_blanking;
    logic        o_rd_en;
    logic [11:0] o_rd_addr;
    logic [47:0] i_rd_data;
    logic        o_hub_clk;
    logic [5:0]  o_hub_rgb;
    logic        o_hub_lat;
    logic        o_hub_oe_n;
    logic [4:0]  o_hub_row;

    hub75_line_tx dut (
        .clk         (clk),
        .rst         (rst),
        .i_clk_div   (i_clk_div),
        .i_tx_start  (i_tx_start),
        .i_init_addr (i_init_addr),
        .i_pix_bit   (i_pix_bit),
        .i_timer_en  (i_timer_en),
        .o_tx_ready  (o_tx_ready),
        .o_blanking  (o_blanking),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_hub_clk   (o_hub_clk),
        .o_hub_rgb   (o_hub_rgb),
        .o_hub_lat   (o_hub_lat),
        .o_hub_oe_n  (o_hub_oe_n),
        .o_hub_row   (o_hub_row)
    );

    always #5 clk = ~clk;

    logic [47:0] mem [0:4095];
    always @(posedge clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected panel bits for one address: bit pb of each channel, {B,G,R} per segment.
    function automatic logic [5:0] model_rgb(input logic [11:0] a, input logic [2:0] pb);
        logic [47:0] w;
        logic [5:0]  r;
        w = mem[a];
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 3; c++)
                r[s*3+c] = w[s*24 + c*8 + int'(pb)];
        return r;
    endfunction

    logic        mon_clr = 1'b0;
    logic [11:0] cur_init;
    logic [2:0]  cur_pb;
    int rise_cnt, row_rise, rd_cnt, rd_err, rgb_err;
    int hi_min, hi_max, lo_min, lo_max, run_len;
    int lat_cycles, blank_low, oe_low, oe_bad, lat_viol;
    logic       prev_clk;
    logic [4:0] row_last;
    logic [5:0] cap [0:63];

    always @(negedge clk) begin
        if (mon_clr) begin
            rise_cnt = 0; row_rise = 0; rd_cnt = 0; rd_err = 0; rgb_err = 0;
            hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0; run_len = 0;
            lat_cycles = 0; blank_low = 0; oe_low = 0; oe_bad = 0; lat_viol = 0;
            row_last = '1;
            prev_clk = o_hub_clk;
        end else begin
            if (i_tx_start) begin
                row_rise = 0;
                rd_cnt   = 0;
            end
            if (o_rd_en) begin
                if (o_rd_addr != 12'(cur_init + 12'(rd_cnt))) rd_err++;
                rd_cnt++;
            end
            if (o_hub_clk != prev_clk) begin
                if (prev_clk) begin
                    if (run_len < hi_min) hi_min = run_len;
                    if (run_len > hi_max) hi_max = run_len;
                end else begin
                    if (row_rise > 0) begin
                        if (run_len < lo_min) lo_min = run_len;
                        if (run_len > lo_max) lo_max = run_len;
                    end
                    if (row_rise < 64) cap[row_rise] = o_hub_rgb;
                    if (o_hub_rgb != model_rgb(12'(cur_init + 12'(row_rise)), cur_pb)) rgb_err++;
                    row_rise++;
                    rise_cnt++;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_clk = o_hub_clk;
            if (o_hub_lat) begin
                lat_cycles++;
                row_last = o_hub_row;
                if (!o_blanking) lat_viol++;
            end
            if (!o_blanking) blank_low++;
            if (!o_hub_oe_n) oe_low++;
            if (i_timer_en ? (o_hub_oe_n != o_blanking) : !o_hub_oe_n) oe_bad++;
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic start_row(input logic [11:0] a, input logic [2:0] pb, input logic [3:0] dv);
        cur_init = a;
        cur_pb   = pb;
        @(posedge clk); #1;
        i_init_addr = a;
        i_pix_bit   = pb;
        i_clk_div   = dv;
        i_tx_start  = 1'b1;
        @(posedge clk); #1 i_tx_start = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!o_tx_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(o_tx_ready), 64'd1);
    endtask

    task automatic wait_blank(input string tag, input int budget);
        int n = 0;
        while (!o_blanking && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(o_blanking), 64'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({o_tx_ready, o_blanking, o_rd_en, o_hub_clk, o_hub_lat, o_hub_oe_n}),
              64'b110001);
        check({tag, "_data"}, 64'({o_rd_addr, o_hub_rgb, o_hub_row}), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset(tag);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            logic [11:0] av;
            av = 12'(a);
            mem[a] = {av[7:0] ^ 8'hA5, av[11:4], ~av[7:0],
                      av[11:4] ^ 8'h3C, ~av[7:0], av[7:0]};
        end
        rst = 1'b1; i_clk_div = 4'd0; i_tx_start = 1'b0; i_init_addr = '0;
        i_pix_bit = '0; i_timer_en = 1'b0; cur_init = '0; cur_pb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Row 0, plane 0, fastest clock, panel dark.
        clear_mon();
        start_row(12'd0, 3'd0, 4'd0);
        wait_ready("t1_ready", 1000);
        wait_blank("t1_blank", 1000);
        check("t1_rises", 64'(rise_cnt), 64'd64);
        check("t1_hi", 64'({hi_min[7:0], hi_max[7:0]}), 64'h0101);
        check("t1_lo", 64'({lo_min[7:0], lo_max[7:0]}), 64'h0101);
        check("t1_r0_p0", 64'(cap[0][0]), 64'd0);
        check("t1_r0_p1", 64'(cap[1][0]), 64'd1);
        check("t1_g0_p0", 64'(cap[0][1]), 64'd1);
        check("t1_rgb", 64'(rgb_err), 64'd0);
        check("t1_rdaddr", 64'({rd_err[15:0], rd_cnt[15:0]}), 64'd64);
        check("t1_lat", 64'(lat_cycles), 64'd2);
        check("t1_row", 64'(row_last), 64'd0);
        check("t1_blank_low", 64'(blank_low), 64'd16);
        check("t1_oe_low", 64'(oe_low), 64'd0);

        // Plane 7 with OE enabled: 16 << 7 cycles on.
        i_timer_en = 1'b1;
        clear_mon();
        start_row(12'd0, 3'd7, 4'd0);
        wait_ready("t2_ready", 1000);
        wait_blank("t2_blank", 3000);
        check("t2_oe_low", 64'(oe_low), 64'd2048);
        check("t2_blank_low", 64'(blank_low), 64'd2048);
        check("t2_oe_bad", 64'(oe_bad), 64'd0);
        check("t2_rgb", 64'(rgb_err), 64'd0);

        // Second row shifts during a long display and must wait for blanking.
        clear_mon();
        start_row(12'd0, 3'd7, 4'd0);
        wait_ready("t3a_ready", 1000);
        start_row(12'd64, 3'd0, 4'd0);
        repeat (300) @(negedge clk);
        check("t3_wait", 64'({o_tx_ready, o_hub_lat, o_blanking, o_hub_clk}), 64'd0);
        check("t3_rise_mid", 64'(rise_cnt), 64'd128);
        wait_ready("t3b_ready", 3000);
        wait_blank("t3_blank", 1000);
        check("t3_lat", 64'(lat_cycles), 64'd4);
        check("t3_lat_viol", 64'(lat_viol), 64'd0);
        check("t3_row", 64'(row_last), 64'd1);
        check("t3_blank_low", 64'(blank_low), 64'd2064);
        check("t3_oe_low", 64'(oe_low), 64'd2064);
        check("t3_rgb", 64'(rgb_err), 64'd0);

        // Row index folding and address wrap.
        i_timer_en = 1'b0;
        clear_mon();
        start_row(12'(33*64), 3'd3, 4'd1);
        wait_ready("t4a_ready", 2000);
        wait_blank("t4a_blank", 1000);
        check("t4a_row", 64'(row_last), 64'd1);
        check("t4a_rgb", 64'(rgb_err), 64'd0);
        clear_mon();
        start_row(12'd4090, 3'd5, 4'd0);
        wait_ready("t4b_ready", 1000);
        wait_blank("t4b_blank", 1000);
        check("t4b_row", 64'(row_last), 64'd31);
        check("t4b_rdaddr", 64'({rd_err[15:0], rd_cnt[15:0]}), 64'd64);
        check("t4b_p5", 64'(cap[5][0]), 64'd1);
        check("t4b_p6", 64'(cap[6][0]), 64'd0);
        check("t4b_rgb", 64'(rgb_err), 64'd0);

        // Divider 3, input changed mid-row: phases stay 4 cycles.
        clear_mon();
        start_row(12'd128, 3'd2, 4'd3);
        repeat (40) @(negedge clk);
        i_clk_div = 4'd0;
        wait_ready("t5_ready", 2000);
        wait_blank("t5_blank", 1000);
        check("t5_rises", 64'(rise_cnt), 64'd64);
        check("t5_hi", 64'({hi_min[7:0], hi_max[7:0]}), 64'h0404);
        check("t5_lo", 64'({lo_min[7:0], lo_max[7:0]}), 64'h0404);
        check("t5_rgb", 64'(rgb_err), 64'd0);

        // Asynchronous reset mid-shift and mid-latch, then a normal row.
        i_timer_en = 1'b1;
        start_row(12'd0, 3'd0, 4'd2);
        repeat (20) @(negedge clk);
        pulse_reset("t6_rst_shift");
        begin
            int n = 0;
            start_row(12'd0, 3'd0, 4'd0);
            while (!o_hub_lat && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("t6_lat_seen", 64'(o_hub_lat), 64'd1);
        end
        pulse_reset("t6_rst_latch");
        repeat (5) @(negedge clk);
        check("t6_no_display", 64'({o_blanking, o_hub_oe_n, o_hub_lat}), 64'b110);
        clear_mon();
        start_row(12'(5*64), 3'd1, 4'd0);
        wait_ready("t6_ready", 1000);
        wait_blank("t6_blank", 1000);
        check("t6_rises", 64'(rise_cnt), 64'd64);
        check("t6_rgb", 64'(rgb_err), 64'd0);
        check("t6_row", 64'(row_last), 64'd5);
        check("t6_oe_low", 64'(oe_low), 64'd32);
        check("t6_blank_low", 64'(blank_low), 64'd32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hub75_line_tx.md
Name: hub75_line_tx

Overview:
- Responder/physical end of the HUB75 row-control handshake.
- On each `i_tx_start` it fetches one row of pixels from the frame buffer and serialises one bit-plane onto the panel RGB lines with a divided shift clock.
- It waits for the current display slot to end, latches the row, then drives OE for a binary-weighted on-time.
- It reports `o_tx_ready` and `o_blanking` back to the row sequencer.

Parameters:
- hpixel_p, 64, display width in pixels.
- vpixel_p, 64, display height in pixels.
- bpp_p, 8, bits per colour channel.
- segments_p, 2, panel segments driven in parallel (one RGB triple each).
- base_cycles_p, 16, clk cycles of OE-on time for bit-plane 0.
- Localparams: addr_width_p = $clog2(hpixel_p*vpixel_p); pix_bit_width_p = $clog2(bpp_p); row_width_p = $clog2(vpixel_p/segments_p).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_clk_div  in  4  shift-clock divider; half-period = i_clk_div+1 clk cycles
- i_tx_start  in  1  one-cycle request to transmit a row
- i_init_addr  in  addr_width_p  frame-buffer address of pixel 0 of the row
- i_pix_bit  in  pix_bit_width_p  bit-plane to serialise
- i_timer_en  in  1  gates OE; when 0 the panel stays dark, timing still runs
- o_tx_ready  out  1  shifter idle, next row may start
- o_blanking  out  1  1 while no display slot is running
- o_rd_en  out  1  frame-buffer read strobe
- o_rd_addr  out  addr_width_p  frame-buffer read address
- i_rd_data  in  segments_p*3*bpp_p  read word, valid 1 cycle after o_rd_en; segment s at [s*3*bpp_p +: 3*bpp_p], order R,G,B from LSB
- o_hub_clk  out  1  panel shift clock
- o_hub_rgb  out  segments_p*3  panel data, segment s at [s*3 +: 3] = {B,G,R}
- o_hub_lat  out  1  panel latch
- o_hub_oe_n  out  1  panel output enable, active low
- o_hub_row  out  row_width_p  panel row address

Behaviour:
- Reset values: o_tx_ready=1, o_blanking=1, o_rd_en=0, o_rd_addr=0, o_hub_clk=0, o_hub_rgb=0, o_hub_lat=0, o_hub_oe_n=1, o_hub_row=0; FSM in IDLE; timer stopped.
- Reset mid-operation returns everything to reset values immediately. No partial latch or OE pulse survives.
- Shifter FSM states: IDLE, SHIFT, WAIT_BLANK, LATCH.
- IDLE:
  - o_tx_ready=1.
  - On i_tx_start, capture i_init_addr, i_pix_bit and i_clk_div; go to SHIFT.
  - o_tx_ready is 0 from the next cycle.
  - i_tx_start outside IDLE is ignored.
- SHIFT, per pixel p = 0..hpixel_p-1:
  - Read address = init_addr + p, modulo 2^addr_width_p.
  - Data bit for each channel = bit pix_bit of that channel.
  - o_hub_rgb is updated while o_hub_clk is low, at least one clk before the rising edge.
  - o_hub_clk is high for (div+1) cycles and low for (div+1) cycles.
  - Exactly hpixel_p rising edges per row. o_hub_clk is 0 outside SHIFT.
  - After the last falling edge, go to WAIT_BLANK.
- WAIT_BLANK: hold until o_blanking=1 (immediate if already 1), then go to LATCH.
- LATCH:
  - Drive o_hub_lat=1 for exactly 2 cycles with OE off.
  - On the first latch cycle, o_hub_row <= row field of captured init_addr, i.e. (init_addr / hpixel_p) mod (vpixel_p/segments_p).
  - Then start the display timer and return to IDLE; o_tx_ready=1 the following cycle.
- Display timer:
  - Loads base_cycles_p << pix_bit, using the pix_bit of the row just latched.
  - o_blanking=0 while the count is nonzero.
  - o_hub_oe_n = ~(timer running & i_timer_en), sampled each cycle.
  - On expiry, o_blanking rises in the same cycle OE turns off.
  - The timer runs regardless of i_timer_en, so blanking always toggles and the sequencer cannot deadlock.
- Overlap: the next row may shift while the previous row is displayed, so at most one row sits in the shift register plus one latched.
- i_clk_div change mid-row has no effect until the next i_tx_start.
- i_clk_div=0 gives the fastest shift clock, period 2 clk.

Decomposition:
- Package hub75_pkg holds:
  - the shifter state enum;
  - a function computing row index from address;
  - the width localparams shared with the row sequencer.
- Sub-module hub75_bcm_timer (load, pix_bit, running/blanking out) is natural. It is reused by any future gamma/brightness logic.

Test Plan:
- Reset, then tx_start with init_addr=0, pix_bit=0, clk_div=0, mem[p]=p:
  - 64 hub_clk rising edges of period 2;
  - R0 bit 0 on segment 0 alternates 0,1,…;
  - lat high 2 cycles;
  - hub_row=0;
  - blanking low for 16 cycles;
  - oe_n stays 1 (timer_en=0).
- timer_en=1, pix_bit=7: oe_n low exactly 16<<7 = 2048 cycles; blanking rises the same cycle oe_n goes high.
- Second tx_start issued during display, with a long display: second row shifts, FSM waits in WAIT_BLANK; lat asserts only after blanking rises; tx_ready stays low until then.
- init_addr=33*64, segments_p=2: hub_row=1 after latch; address wraps correctly at 4095 with init_addr=4090.
- clk_div=3, change i_clk_div to 0 mid-row: all high/low phases stay 4 cycles until the row ends.
- Assert rst mid-SHIFT and during LATCH: all outputs return to reset values asynchronously; next tx_start works normally.
